hf_section_xfer: RTL and testbench
==================================

// Module: hf_section_xfer
// PURPOSE
//  Per-section transfer sequencer that sits downstream of the soft controller.
//  - Consumes one section's LEN/DIR/EN_STB command (the controller instantiates four).
//  - Paces word moves against the section port's ready signal and tracks the residue.
//  - On finish or abort, toggles DONE_STB back to the controller/IRQ logic.
// PARAMETERS
//  LEN_W   24   width of LEN and REMAIN (word count)
// PORTS
//  CLK           in   1      clock
//  RST           in   1      synchronous reset, active-low
//  LEN           in   LEN_W  transfer length in words, valid when EN_STB changes
//  DIR           in   1      direction, latched with LEN (1 = toward DRAM)
//  EN_STB        in   1      toggle strobe; any level change = new command
//  ABORT         in   1      level; terminate the running transfer
//  PORT_RDY      in   1      section port can move one word this cycle
//  WORD_STB      out  1      registered 1-cycle pulse per word moved
//  WORD_DIR      out  1      latched DIR of current command
//  BUSY          out  1      command accepted and not yet finished
//  REMAIN        out  LEN_W  words still to move
//  DONE_STB      out  1      toggles once per completed or aborted command
//  DONE_ABORTED  out  1      1 if the last completion was due to ABORT
//  OVERRUN       out  1      sticky; a command arrived while not IDLE
// BEHAVIOUR
//  Reset (RST=0 at posedge): all outputs 0; en_stb_r=0; state=IDLE.
//   - RST mid-transfer discards the transfer. No DONE_STB toggle.
//  Edge detect:
//   - cmd_edge = EN_STB ^ en_stb_r.
//   - en_stb_r <= EN_STB every cycle, in every state.
//  States: IDLE, RUN, FINISH.
//  IDLE, cmd_edge=1 at edge k: latch LEN->REMAIN, DIR->WORD_DIR, DONE_ABORTED<=0.
//   - LEN!=0: state<=RUN, BUSY<=1.
//   - LEN==0: state<=FINISH, BUSY<=1 (no WORD_STB is issued).
//  RUN, evaluated each edge in priority order:
//   1. ABORT=1: state<=FINISH, DONE_ABORTED<=1, REMAIN holds, no WORD_STB.
//      ABORT wins over PORT_RDY in the same cycle.
//   2. PORT_RDY=1: WORD_STB<=1, REMAIN<=REMAIN-1.
//      If REMAIN==1, also state<=FINISH.
//   3. Otherwise: WORD_STB<=0, hold.
//  FINISH, one cycle: DONE_STB<=~DONE_STB, BUSY<=0, WORD_STB<=0, state<=IDLE.
//  Latency:
//   - Command edge k -> first WORD_STB after edge k+1 at the earliest.
//   - Last WORD_STB cycle -> DONE_STB toggles one edge later; BUSY falls on the same edge.
//  cmd_edge while RUN/FINISH: command ignored (LEN/DIR not latched), OVERRUN<=1.
//   - OVERRUN is cleared only by reset.
//  ABORT in IDLE/FINISH: no effect.
//  REMAIN never wraps: decrement only when REMAIN!=0 in RUN.
//   - Full LEN_W range is supported (2^LEN_W-1 words max).
//  WORD_STB is 0 in every state except the cycle after a RUN+PORT_RDY edge.
// TESTING
//  1. LEN=3, DIR=1, toggle EN_STB, PORT_RDY=1 -> BUSY next cycle; WORD_STB high 3 consecutive
//     cycles; REMAIN 3->2->1->0; DONE_STB toggles once; DONE_ABORTED=0; WORD_DIR=1.
//  2. LEN=0, toggle EN_STB -> zero WORD_STB pulses; DONE_STB toggles 2 edges after the command;
//     BUSY high for exactly 1 cycle.
//  3. LEN=4, PORT_RDY pattern 1,0,0,1,1,0,1 -> exactly 4 WORD_STB pulses aligned 1 cycle after
//     each sampled PORT_RDY=1 in RUN; DONE after the 4th.
//  4. LEN=8, PORT_RDY=1, ABORT=1 when REMAIN=5, together with PORT_RDY -> no WORD_STB that
//     cycle; REMAIN stays 5; DONE_ABORTED=1; DONE_STB toggles; next command clears DONE_ABORTED.
//  5. LEN=10 running, toggle EN_STB with LEN=2 -> OVERRUN=1; transfer still moves 10 words;
//     LEN=2 never executes.
//  6. RST=0 while REMAIN=6 -> next cycle all outputs 0, state IDLE, no DONE_STB toggle; a fresh
//     EN_STB toggle (0->1) then starts normally.

Source files
------------

// File: rtl/hf_section_xfer.sv
// rtl/hf_section_xfer.sv - per-section word-transfer sequencer with toggle command/done handshakes
module hf_section_xfer #(
    parameter int LEN_W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [LEN_W-1:0] LEN,
    input  logic             DIR,
    input  logic             EN_STB,
    input  logic             ABORT,
    input  logic             PORT_RDY,
    output logic             WORD_STB,
    output logic             WORD_DIR,
    output logic             BUSY,
    output logic [LEN_W-1:0] REMAIN,
    output logic             DONE_STB,
    output logic             DONE_ABORTED,
    output logic             OVERRUN
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic               en_stb_r_q, en_stb_r_d;
    logic [LEN_W-1:0]   remain_q, remain_d;
    logic               word_dir_q, word_dir_d;
    logic               busy_q, busy_d;
    logic               word_stb_q, word_stb_d;
    logic               done_stb_q, done_stb_d;
    logic               done_aborted_q, done_aborted_d;
    logic               overrun_q, overrun_d;
    logic               cmd_edge;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q        <= ST_IDLE;
            en_stb_r_q     <= 1'b0;
            remain_q       <= '0;
            word_dir_q     <= 1'b0;
            busy_q         <= 1'b0;
            word_stb_q     <= 1'b0;
            done_stb_q     <= 1'b0;
            done_aborted_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            en_stb_r_q     <= en_stb_r_d;
            remain_q       <= remain_d;
            word_dir_q     <= word_dir_d;
            busy_q         <= busy_d;
            word_stb_q     <= word_stb_d;
            done_stb_q     <= done_stb_d;
            done_aborted_q <= done_aborted_d;
            overrun_q      <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        en_stb_r_d     = EN_STB;
        remain_d       = remain_q;
        word_dir_d     = word_dir_q;
        busy_d         = busy_q;
        word_stb_d     = 1'b0;
        done_stb_d     = done_stb_q;
        done_aborted_d = done_aborted_q;
        overrun_d      = overrun_q;
        cmd_edge       = EN_STB ^ en_stb_r_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_edge) begin
                    remain_d       = LEN;
                    word_dir_d     = DIR;
                    done_aborted_d = 1'b0;
                    busy_d         = 1'b1;
                    // A zero-length command still passes through FINISH so the done toggle fires.
                    state_d        = (LEN != '0) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                if (cmd_edge) begin
                    overrun_d = 1'b1;
                end
                if (ABORT) begin
                    done_aborted_d = 1'b1;
                    state_d        = ST_FINISH;
                end else if (PORT_RDY) begin
                    word_stb_d = 1'b1;
                    if (remain_q != '0) begin
                        remain_d = remain_q - LEN_W'(1);
                    end
                    if (remain_q <= LEN_W'(1)) begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                if (cmd_edge) begin
                    overrun_d = 1'b1;
                end
                done_stb_d = ~done_stb_q;
                busy_d     = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign WORD_STB     = word_stb_q;
    assign WORD_DIR     = word_dir_q;
    assign BUSY         = busy_q;
    assign REMAIN       = remain_q;
    assign DONE_STB     = done_stb_q;
    assign DONE_ABORTED = done_aborted_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_hf_section_xfer.sv
// tb/tb_hf_section_xfer.sv - randomized scoreboard bench for hf_section_xfer
module tb_hf_section_xfer;
    localparam int LEN_W = 24;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic [LEN_W-1:0] LEN = '0;
    logic             DIR = 1'b0;
    logic             EN_STB = 1'b0;
    logic             ABORT = 1'b0;
    logic             PORT_RDY = 1'b0;
    logic             WORD_STB;
    logic             WORD_DIR;
    logic             BUSY;
    logic [LEN_W-1:0] REMAIN;
    logic             DONE_STB;
    logic             DONE_ABORTED;
    logic             OVERRUN;

    hf_section_xfer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .LEN(LEN), .DIR(DIR), .EN_STB(EN_STB),
        .ABORT(ABORT), .PORT_RDY(PORT_RDY), .WORD_STB(WORD_STB),
        .WORD_DIR(WORD_DIR), .BUSY(BUSY), .REMAIN(REMAIN), .DONE_STB(DONE_STB),
        .DONE_ABORTED(DONE_ABORTED), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int edge_n;
        bit aborted;
        bit dir;
        int remain;
        bit ovr;
    } done_t;

    int    word_q[$];
    done_t done_q[$];
    done_t mon_d;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 0;
    bit    exp_ovr = 0;
    logic  done_prev = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every word pulse and every done toggle must match a scoreboard entry.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (WORD_STB) begin
                chk("word_expected", word_q.size() != 0, 1);
                if (word_q.size() != 0) chk("word_edge", cyc, word_q.pop_front());
            end
            if (DONE_STB !== done_prev) begin
                done_prev = DONE_STB;
                chk("done_expected", done_q.size() != 0, 1);
                if (done_q.size() != 0) begin
                    mon_d = done_q.pop_front();
                    chk("done_edge", cyc, mon_d.edge_n);
                    chk("done_aborted", DONE_ABORTED, mon_d.aborted);
                    chk("word_dir", WORD_DIR, mon_d.dir);
                    chk("remain_at_done", REMAIN, mon_d.remain);
                    chk("busy_at_done", BUSY, 0);
                    chk("overrun_at_done", OVERRUN, mon_d.ovr);
                end
            end
        end
    end

    // Model: one word per ready edge after the command edge until len words or an abort;
    // done toggles one edge after the final word/abort edge (or after the command edge if len==0).
    task automatic do_cmd(input int len, input bit dir, input int rdy_pct,
                          input bit [15:0] pat, input int pat_n,
                          input int abort_word, input int abort_pct, input int ovr_at);
        int    e;
        int    words;
        int    i;
        bit    ab;
        done_t d;
        @(negedge CLK);
        LEN      = LEN_W'(len);
        DIR      = dir;
        EN_STB   = ~EN_STB;
        PORT_RDY = 1'($urandom);
        ABORT    = 1'($urandom);
        words    = 0;
        ab       = 0;
        if (len == 0) begin
            @(negedge CLK);
            chk("busy_after_cmd", BUSY, 1);
            e = cyc;
            PORT_RDY = 1'($urandom);
            ABORT    = 1'($urandom);
        end else begin
            for (i = 1; i <= 1000; i++) begin
                @(negedge CLK);
                if (i == 1) chk("busy_after_cmd", BUSY, 1);
                e        = cyc + 1;
                LEN      = LEN_W'($urandom);
                DIR      = 1'($urandom);
                PORT_RDY = (i <= pat_n) ? pat[i-1] : ($urandom_range(99) < rdy_pct);
                ABORT    = (words == abort_word) || ($urandom_range(99) < abort_pct);
                if (words == abort_word) PORT_RDY = 1'b1;
                if (i == ovr_at) begin
                    LEN     = LEN_W'(2);
                    EN_STB  = ~EN_STB;
                    exp_ovr = 1'b1;
                end
                if (ABORT) begin
                    ab = 1;
                    break;
                end
                if (PORT_RDY) begin
                    word_q.push_back(e);
                    words++;
                    if (words == len) break;
                end
            end
            chk("transfer_bounded", i <= 1000, 1);
        end
        d.edge_n  = e + 1;
        d.aborted = ab;
        d.dir     = dir;
        d.remain  = len - words;
        d.ovr     = exp_ovr;
        done_q.push_back(d);
        @(negedge CLK);
        PORT_RDY = 1'($urandom);
        ABORT    = 1'($urandom);
        repeat ($urandom_range(0, 2)) @(negedge CLK);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_word_stb"}, WORD_STB, 0);
        chk({tag, "_word_dir"}, WORD_DIR, 0);
        chk({tag, "_busy"}, BUSY, 0);
        chk({tag, "_remain"}, REMAIN, 0);
        chk({tag, "_done_stb"}, DONE_STB, 0);
        chk({tag, "_done_aborted"}, DONE_ABORTED, 0);
        chk({tag, "_overrun"}, OVERRUN, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk_all_zero("reset");
        RST       = 1'b1;
        done_prev = 1'b0;
        mon_en    = 1;

        do_cmd(3, 1, 100, 16'h0, 0, -1, 0, -1);
        do_cmd(0, 0, 50, 16'h0, 0, -1, 0, -1);
        do_cmd(4, 0, 0, 16'b1011001, 7, -1, 0, -1);
        do_cmd(8, 1, 100, 16'h0, 0, 3, 0, -1);
        do_cmd(2, 0, 100, 16'h0, 0, -1, 0, -1);

        repeat (40) begin
            do_cmd($urandom_range(0, 6), 1'($urandom), $urandom_range(30, 100),
                   16'h0, 0, -1, $urandom_range(0, 8), -1);
        end

        do_cmd(10, 0, 100, 16'h0, 0, -1, 0, 3);
        @(negedge CLK);
        chk("overrun_sticky", OVERRUN, 1);

        repeat (3) @(negedge CLK);
        mon_en = 0;
        @(negedge CLK);
        LEN      = LEN_W'(10);
        DIR      = 1'b1;
        EN_STB   = ~EN_STB;
        PORT_RDY = 1'b1;
        ABORT    = 1'b0;
        repeat (5) @(negedge CLK);
        chk("remain_before_reset", REMAIN, 6);
        RST    = 1'b0;
        EN_STB = 1'b0;
        @(negedge CLK);
        chk_all_zero("midreset");
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk_all_zero("post_reset");
        word_q.delete();
        done_q.delete();
        done_prev = 1'b0;
        exp_ovr   = 0;
        mon_en    = 1;
        do_cmd(5, 1, 70, 16'h0, 0, -1, 0, -1);

        repeat (4) @(negedge CLK);
        chk("word_q_drained", word_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
